// File: rtl/riscv_result_checker.sv
// riscv_result_checker: self-check block that sits beside RISCV_TOP.
// It compares OUTPUT_PORT against a loadable answer table, keyed on NUM_INST.
// Optional feature macro: RISCV_CHECKER_MASK_EN adds a per-entry compare mask
// that is loaded through LOAD_MASK.
//
// state  | meaning
// S_IDLE | table loadable, waiting for START; last run's results visible
// S_RUN  | counting cycles and checking entries against the core
// S_DONE | results frozen until CLEAR
module riscv_result_checker #(
    parameter int NUM_TEST    = 40,
    parameter int IDX_W       = 6,
    parameter int DWIDTH      = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_EN,
    input  logic [IDX_W-1:0]  LOAD_IDX,
    input  logic [DWIDTH-1:0] LOAD_NUM_INST,
    input  logic [DWIDTH-1:0] LOAD_ANS,
`ifdef RISCV_CHECKER_MASK_EN
    input  logic [DWIDTH-1:0] LOAD_MASK,
`endif
    input  logic              LOAD_VALID,
    input  logic              START,
    input  logic              CLEAR,
    input  logic              STOP_ON_FAIL,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ALL_PASS,
    output logic              TIMEOUT,
    output logic [CNT_W-1:0]  PASS_CNT,
    output logic [CNT_W-1:0]  FAIL_CNT,
    output logic [CNT_W-1:0]  MISSED_CNT,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic              FAIL_SEEN,
    output logic [CNT_W-1:0]  CYCLE
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // A zero TIMEOUT_CYC wraps this to all-ones, but the compare is gated off then.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [NUM_TEST-1:0] valid_q, valid_d, checked_q, checked_d;
    logic [DWIDTH-1:0]   num_q [NUM_TEST];
    logic [DWIDTH-1:0]   ans_q [NUM_TEST];
`ifdef RISCV_CHECKER_MASK_EN
    logic [DWIDTH-1:0]   mask_q [NUM_TEST];
`endif
    logic [CNT_W-1:0]    pass_q, pass_d, fail_q, fail_d, missed_q, missed_d, cycle_q, cycle_d;
    logic [IDX_W-1:0]    fail_idx_q, fail_idx_d, low_fail;
    logic                fail_seen_q, fail_seen_d, timeout_q, timeout_d, sof_q, sof_d;
    logic [NUM_TEST-1:0] hit, pass_v, fail_v, load_sel;
    logic                any_fail, timeout_hit, stop_fail;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TEST-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_TEST; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Per-entry match/pass/fail vectors, load select and lowest failing index.
    always_comb begin
        hit      = '0;
        pass_v   = '0;
        fail_v   = '0;
        load_sel = '0;
        low_fail = '0;
        for (int i = 0; i < NUM_TEST; i++) begin
            hit[i] = valid_q[i] & ~checked_q[i] & (NUM_INST == num_q[i]);
`ifdef RISCV_CHECKER_MASK_EN
            pass_v[i] = hit[i] & (((OUTPUT_PORT ^ ans_q[i]) & mask_q[i]) == '0);
`else
            pass_v[i] = hit[i] & (OUTPUT_PORT == ans_q[i]);
`endif
            fail_v[i]   = hit[i] & ~pass_v[i];
            load_sel[i] = LOAD_EN & (state_q == S_IDLE) & (LOAD_IDX == IDX_W'(i));
        end
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            if (fail_v[i]) low_fail = IDX_W'(i);
        end
    end

    assign any_fail    = |fail_v;
    assign stop_fail   = any_fail & sof_q;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cycle_q == TO_LAST);

    // Next-state and run bookkeeping.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        checked_d   = checked_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        missed_d    = missed_q;
        cycle_d     = cycle_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        timeout_d   = timeout_q;
        sof_d       = sof_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d     = S_RUN;
                    checked_d   = '0;
                    pass_d      = '0;
                    fail_d      = '0;
                    missed_d    = '0;
                    cycle_d     = '0;
                    fail_idx_d  = '0;
                    fail_seen_d = 1'b0;
                    timeout_d   = 1'b0;
                    sof_d       = STOP_ON_FAIL;
                end
                for (int i = 0; i < NUM_TEST; i++) begin
                    if (load_sel[i]) begin
                        valid_d[i]   = LOAD_VALID;
                        checked_d[i] = 1'b0;
                    end
                end
            end
            S_RUN: begin
                cycle_d   = cycle_q + 1'b1;
                checked_d = checked_q | hit;
                pass_d    = sat_add(pass_q, popcount(pass_v));
                fail_d    = sat_add(fail_q, popcount(fail_v));
                if (any_fail && !fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    fail_idx_d  = low_fail;
                end
                if (HALT || stop_fail || timeout_hit) begin
                    state_d   = S_DONE;
                    missed_d  = popcount(valid_q & ~checked_d);
                    timeout_d = !HALT && !stop_fail;
                end
            end
            S_DONE: begin
                if (CLEAR) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            checked_q   <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            missed_q    <= '0;
            cycle_q     <= '0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
            timeout_q   <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            checked_q   <= checked_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            missed_q    <= missed_d;
            cycle_q     <= cycle_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
            timeout_q   <= timeout_d;
            sof_q       <= sof_d;
        end
    end

    // Answer table storage, written only through the IDLE load port.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_TEST; i++) begin
            if (RST) begin
                num_q[i]  <= '0;
                ans_q[i]  <= '0;
`ifdef RISCV_CHECKER_MASK_EN
                mask_q[i] <= '0;
`endif
            end else if (load_sel[i]) begin
                num_q[i]  <= LOAD_NUM_INST;
                ans_q[i]  <= LOAD_ANS;
`ifdef RISCV_CHECKER_MASK_EN
                mask_q[i] <= LOAD_MASK;
`endif
            end
        end
    end

    assign BUSY       = (state_q == S_RUN);
    assign DONE       = (state_q == S_DONE);
    assign ALL_PASS   = DONE & ~fail_seen_q & ~timeout_q & (missed_q == '0);
    assign TIMEOUT    = timeout_q;
    assign PASS_CNT   = pass_q;
    assign FAIL_CNT   = fail_q;
    assign MISSED_CNT = missed_q;
    assign FAIL_IDX   = fail_idx_q;
    assign FAIL_SEEN  = fail_seen_q;
    assign CYCLE      = cycle_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Directed bench for riscv_result_checker (small timeout for the timeout case).
module tb_riscv_result_checker;

    localparam int IDX_W  = 6;
    localparam int DWIDTH = 32;
    localparam int CNT_W  = 32;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              LOAD_EN = 1'b0;
    logic [IDX_W-1:0]  LOAD_IDX = '0;
    logic [DWIDTH-1:0] LOAD_NUM_INST = '0;
    logic [DWIDTH-1:0] LOAD_ANS = '0;
`ifdef RISCV_CHECKER_MASK_EN
    logic [DWIDTH-1:0] LOAD_MASK = '0;
`endif
    logic              LOAD_VALID = 1'b0;
    logic              START = 1'b0;
    logic              CLEAR = 1'b0;
    logic              STOP_ON_FAIL = 1'b0;
    logic [DWIDTH-1:0] NUM_INST = '0;
    logic [DWIDTH-1:0] OUTPUT_PORT = '0;
    logic              HALT = 1'b0;
    logic              BUSY, DONE, ALL_PASS, TIMEOUT, FAIL_SEEN;
    logic [CNT_W-1:0]  PASS_CNT, FAIL_CNT, MISSED_CNT, CYCLE;
    logic [IDX_W-1:0]  FAIL_IDX;

    int checks = 0;
    int errors = 0;

    riscv_result_checker #(
        .NUM_TEST(40), .IDX_W(IDX_W), .DWIDTH(DWIDTH), .CNT_W(CNT_W), .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX),
        .LOAD_NUM_INST(LOAD_NUM_INST), .LOAD_ANS(LOAD_ANS),
`ifdef RISCV_CHECKER_MASK_EN
        .LOAD_MASK(LOAD_MASK),
`endif
        .LOAD_VALID(LOAD_VALID), .START(START), .CLEAR(CLEAR),
        .STOP_ON_FAIL(STOP_ON_FAIL), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
        .HALT(HALT), .BUSY(BUSY), .DONE(DONE), .ALL_PASS(ALL_PASS), .TIMEOUT(TIMEOUT),
        .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .MISSED_CNT(MISSED_CNT),
        .FAIL_IDX(FAIL_IDX), .FAIL_SEEN(FAIL_SEEN), .CYCLE(CYCLE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic load(input int idx, input logic [DWIDTH-1:0] ni, input logic [DWIDTH-1:0] ans,
                        input logic v, input logic [DWIDTH-1:0] mask);
        LOAD_EN       = 1'b1;
        LOAD_IDX      = IDX_W'(idx);
        LOAD_NUM_INST = ni;
        LOAD_ANS      = ans;
        LOAD_VALID    = v;
`ifdef RISCV_CHECKER_MASK_EN
        LOAD_MASK     = mask;
`else
        if (mask == '0) LOAD_VALID = v;
`endif
        step();
        LOAD_EN = 1'b0;
    endtask

    task automatic start(input logic sof);
        START        = 1'b1;
        STOP_ON_FAIL = sof;
        step();
        START = 1'b0;
    endtask

    task automatic drive(input logic [DWIDTH-1:0] ni, input logic [DWIDTH-1:0] op);
        NUM_INST    = ni;
        OUTPUT_PORT = op;
        step();
    endtask

    task automatic halt();
        NUM_INST = '0;
        HALT     = 1'b1;
        step();
        HALT     = 1'b0;
    endtask

    task automatic clear();
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
    endtask

    task automatic load_base();
        load(0, 1, 32'h22,  1'b1, '1);
        load(1, 2, 32'h44,  1'b1, '1);
        load(2, 3, 32'hf00, 1'b1, '1);
        load(3, 4, 32'h44,  1'b1, '1);
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_allpass", ALL_PASS, 0);
        chk("rst_timeout", TIMEOUT, 0);
        chk("rst_counts", {PASS_CNT, FAIL_CNT} | MISSED_CNT, 0);
        chk("rst_fail", {FAIL_SEEN, FAIL_IDX}, 0);
        chk("rst_cycle", CYCLE, 0);

        // All pass, continue mode.
        load_base();
        start(1'b0);
        chk("t1_busy", BUSY, 1);
        drive(1, 32'h22); drive(2, 32'h44); drive(3, 32'hf00); drive(4, 32'h44);
        chk("t1_still_run", BUSY, 1);
        halt();
        chk("t1_done", DONE, 1);
        chk("t1_pass", PASS_CNT, 4);
        chk("t1_fail", FAIL_CNT, 0);
        chk("t1_missed", MISSED_CNT, 0);
        chk("t1_allpass", ALL_PASS, 1);
        chk("t1_cycle", CYCLE, 5);
        start(1'b0);
        chk("t1_start_in_done", DONE, 1);
        clear();
        chk("t1_clear_idle", {BUSY, DONE}, 0);
        chk("t1_kept_pass", PASS_CNT, 4);

        // Stop on fail at entry 1.
        start(1'b1);
        drive(1, 32'h22);
        drive(2, 32'h45);
        chk("t2_done", DONE, 1);
        chk("t2_fail_idx", FAIL_IDX, 1);
        chk("t2_fail_seen", FAIL_SEEN, 1);
        chk("t2_pass", PASS_CNT, 1);
        chk("t2_fail", FAIL_CNT, 1);
        chk("t2_missed", MISSED_CNT, 2);
        chk("t2_allpass", ALL_PASS, 0);
        clear();

        // Same failure, continue mode.
        start(1'b0);
        drive(1, 32'h22); drive(2, 32'h45);
        chk("t3_continue", BUSY, 1);
        drive(3, 32'hf00); drive(4, 32'h44);
        halt();
        chk("t3_pass", PASS_CNT, 3);
        chk("t3_fail", FAIL_CNT, 1);
        chk("t3_fail_idx", FAIL_IDX, 1);
        chk("t3_allpass", ALL_PASS, 0);
        clear();

        // Duplicates, out-of-range load, load in the START cycle.
        do_reset();
        load(5, 7, 32'h10, 1'b1, '1);
        load(45, 8, 32'h10, 1'b1, '1);
        LOAD_EN = 1'b1; LOAD_IDX = IDX_W'(9); LOAD_NUM_INST = 7; LOAD_ANS = 32'h10;
        LOAD_VALID = 1'b1;
`ifdef RISCV_CHECKER_MASK_EN
        LOAD_MASK = '1;
`endif
        start(1'b0);
        LOAD_EN = 1'b0;
        drive(7, 32'h10);
        chk("t4_dup_pass", PASS_CNT, 2);
        halt();
        chk("t4_missed", MISSED_CNT, 0);
        chk("t4_allpass", ALL_PASS, 1);
        clear();

        // Zero valid entries plus HALT.
        do_reset();
        start(1'b0);
        halt();
        chk("t5_empty_allpass", ALL_PASS, 1);
        clear();

        // Timeout with an unreachable entry.
        do_reset();
        load(0, 100, 32'h1, 1'b1, '1);
        start(1'b0);
        NUM_INST = '0;
        n = 0;
        while (!DONE && n < 40) begin
            step();
            n++;
        end
        chk("t6_to_latency", n, 16);
        chk("t6_timeout", TIMEOUT, 1);
        chk("t6_cycle", CYCLE, 16);
        chk("t6_allpass", ALL_PASS, 0);
        chk("t6_missed", MISSED_CNT, 1);
        clear();

        // Reset mid-run after a failure.
        load(1, 2, 32'h44, 1'b1, '1);
        start(1'b0);
        drive(2, 32'h45);
        chk("t7_pre_rst_fail", FAIL_SEEN, 1);
        RST = 1'b1;
        step();
        chk("t7_rst_state", {BUSY, DONE, ALL_PASS, TIMEOUT, FAIL_SEEN}, 0);
        chk("t7_rst_counts", {PASS_CNT, FAIL_CNT} | MISSED_CNT | CYCLE, 0);
        chk("t7_rst_idx", FAIL_IDX, 0);
        RST = 1'b0;
        start(1'b0);
        halt();
        chk("t7_table_wiped", ALL_PASS, 1);
        clear();

`ifdef RISCV_CHECKER_MASK_EN
        do_reset();
        load(3, 3, 32'hf00, 1'b1, 32'hff00);
        start(1'b0);
        drive(3, 32'hf3c);
        halt();
        chk("m_pass", PASS_CNT, 1);
        clear();
        start(1'b0);
        drive(3, 32'he00);
        halt();
        chk("m_fail", FAIL_CNT, 1);
        chk("m_fail_pass", PASS_CNT, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_result_checker.md
Name: riscv_result_checker

Overview:
Synthesizable, parametrised self-check block for RISCV_TOP runs. It holds a loadable table of NUM_TEST (instruction-count, expected-answer) entries and monitors NUM_INST, OUTPUT_PORT and HALT from the core. It keeps pass, fail and missed counts, supports stop-on-fail and continue modes, and has a cycle timeout. It replaces per-bench hard-coded answer tables and sits beside RISCV_TOP in benches and on the FPGA wrapper.

Parameters:
NUM_TEST, 40, number of table entries.
IDX_W, 6, entry index width; must satisfy 2**IDX_W >= NUM_TEST.
DWIDTH, 32, width of NUM_INST, OUTPUT_PORT and the answers.
CNT_W, 32, width of the cycle counter and the pass/fail/missed counters.
TIMEOUT_CYC, 1000000, run-cycle limit; 0 disables the timeout.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
LOAD_EN  input  1  writes a table entry; honoured only in IDLE.
LOAD_IDX  input  IDX_W  entry index; ignored when >= NUM_TEST.
LOAD_NUM_INST  input  DWIDTH  instruction count at which the entry is checked.
LOAD_ANS  input  DWIDTH  expected OUTPUT_PORT value.
LOAD_VALID  input  1  1 = entry active, 0 = entry disabled.
START  input  1  1-cycle pulse, IDLE -> RUN.
CLEAR  input  1  1-cycle pulse, DONE -> IDLE.
STOP_ON_FAIL  input  1  mode select; sampled on START.
NUM_INST  input  DWIDTH  from the core.
OUTPUT_PORT  input  DWIDTH  from the core.
HALT  input  1  from the core.
BUSY  output  1  state == RUN.
DONE  output  1  state == DONE.
ALL_PASS  output  1  valid in DONE only.
TIMEOUT  output  1  run ended by the timeout.
PASS_CNT  output  CNT_W  number of passed entries.
FAIL_CNT  output  CNT_W  number of failed entries.
MISSED_CNT  output  CNT_W  valid entries still unchecked on entering DONE.
FAIL_IDX  output  IDX_W  lowest index of the first failing check.
FAIL_SEEN  output  1  at least one failure in this run.
CYCLE  output  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset: state IDLE. All table entries invalid, all checked bits 0. Every output and counter 0, including FAIL_IDX.
- States:
  - IDLE: LOAD_EN writes the entry and clears its checked bit. START -> RUN, and on that same edge: clear checked bits, counters, FAIL_*, TIMEOUT and CYCLE; latch STOP_ON_FAIL. START and LOAD_EN in the same cycle: the load takes effect and is included in the run.
  - RUN: CYCLE += 1 every cycle. LOAD_EN and START are ignored. Each cycle, every entry with valid & !checked & NUM_INST == entry.num_inst is checked: its checked bit is set, and it passes if OUTPUT_PORT == entry.ans, otherwise it fails.
  - All matching entries are evaluated in the same cycle. PASS_CNT and FAIL_CNT add the popcount of passes and fails. The counters saturate at all-ones.
  - First failure of the run: FAIL_SEEN = 1 and FAIL_IDX = lowest failing index in that cycle. Both hold until the next START.
- RUN -> DONE, priority order, registered (1 cycle after the cause):
  1. HALT = 1.
  2. A failure this cycle with the latched STOP_ON_FAIL = 1.
  3. TIMEOUT_CYC != 0 and CYCLE == TIMEOUT_CYC - 1. This also sets TIMEOUT = 1.
- Checks in the cycle HALT is seen still count.
- On entering DONE: MISSED_CNT = count of valid & !checked entries.
- ALL_PASS = DONE & !FAIL_SEEN & !TIMEOUT & MISSED_CNT == 0.
- DONE: all outputs hold. CLEAR -> IDLE; the table and counters are kept and are cleared by the next START. START in DONE is ignored.
- Boundaries:
  - Zero valid entries plus HALT: ALL_PASS = 1.
  - An entry whose NUM_INST is never reached is counted as missed.
  - Duplicate NUM_INST across entries is legal.
  - RST mid-run returns to the reset state on the next edge, which also wipes the table.

Optional Feature:
RISCV_CHECKER_MASK_EN
- Defined: adds input LOAD_MASK [DWIDTH]. Each entry stores a mask, and the pass test becomes ((OUTPUT_PORT ^ ans) & mask) == 0. The mask resets to 0, so a reset entry matches any value.
- Undefined: no LOAD_MASK port and no mask storage; the pass test is exact equality.

Test Plan:
- Load entries 0..3 = (1,0x22), (2,0x44), (3,0xf00), (4,0x44). START with STOP_ON_FAIL = 0. Drive NUM_INST 1..4 with matching OUTPUT_PORT, then HALT -> DONE, PASS_CNT = 4, FAIL_CNT = 0, MISSED_CNT = 0, ALL_PASS = 1.
- Same table, STOP_ON_FAIL = 1, OUTPUT_PORT = 0x45 at NUM_INST = 2 -> FAIL_IDX = 1, FAIL_SEEN = 1, DONE one cycle later, PASS_CNT = 1, MISSED_CNT = 2, ALL_PASS = 0.
- Same failure with STOP_ON_FAIL = 0 -> the run continues; after HALT, PASS_CNT = 3, FAIL_CNT = 1.
- Entries 5 and 9 both (7,0x10), OUTPUT_PORT = 0x10 at NUM_INST = 7 -> PASS_CNT += 2 in one cycle.
- TIMEOUT_CYC = 16, HALT never asserted -> DONE with TIMEOUT = 1 after 16 RUN cycles, CYCLE = 16, ALL_PASS = 0. Assert RST mid-run in a repeat -> all outputs 0 and state IDLE on the next edge.
- With RISCV_CHECKER_MASK_EN: entry (3,0xf00) with mask 0xff00, OUTPUT_PORT = 0xf3c at NUM_INST = 3 -> pass. OUTPUT_PORT = 0xe00 -> fail.
